// File: rtl/sq_wave_decoder.sv
// Receive-side decoder for the square channel SQ_Out stream: measures high/low run lengths
// and publishes period, duty code, volume and timer value through a one-entry valid/ready slot.
module sq_wave_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 20000
) (
    input  logic             ACLK,
    input  logic             RES,
    input  logic [3:0]       SQ_In,
    input  logic             EN,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [CNT_W-1:0] M_PERIOD,
    output logic [CNT_W-1:0] M_HIGH,
    output logic [3:0]       M_VOL,
    output logic             M_VOL_VAR,
    output logic [1:0]       M_DUTY,
    output logic             M_DUTY_OK,
    output logic [10:0]      M_TIMER,
    output logic             M_TIMER_OK,
    output logic             SILENT,
    output logic             OVERRUN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int               PROD_W    = CNT_W + 3;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);

    // Returns {ok, code}: code k-index when 8*high equals k*period for k in {1,2,4,6}.
    function automatic logic [2:0] classify_duty(input logic [CNT_W-1:0] high,
                                                 input logic [CNT_W-1:0] period);
        logic [PROD_W-1:0] h8;
        logic [PROD_W-1:0] p1;
        h8 = PROD_W'(high) << 3;
        p1 = PROD_W'(period);
        if (h8 == p1) begin
            classify_duty = 3'b100;
        end else if (h8 == (p1 << 1)) begin
            classify_duty = 3'b101;
        end else if (h8 == (p1 << 2)) begin
            classify_duty = 3'b110;
        end else if (h8 == ((p1 << 2) + (p1 << 1))) begin
            classify_duty = 3'b111;
        end else begin
            classify_duty = 3'b000;
        end
    endfunction

    // Returns {ok, timer}: the period maps onto an 11-bit timer only if it is a multiple of 8 in [8, 16384].
    function automatic logic [11:0] classify_timer(input logic [CNT_W-1:0] period);
        if ((period[2:0] == 3'b000) && (period >= CNT_W'(8)) && (period <= CNT_W'(16384))) begin
            classify_timer = {1'b1, 11'((period >> 3) - ONE_C)};
        end else begin
            classify_timer = 12'd0;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             prev_hi_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hcnt_nxt_s;
    logic [CNT_W-1:0] lcnt_r;
    logic [CNT_W-1:0] lcnt_nxt_s;
    logic [3:0]       vol_r;
    logic [3:0]       vol_nxt_s;
    logic             var_r;
    logic             var_nxt_s;
    logic             hi_s;
    logic             rise_s;
    logic             start_s;
    logic             complete_s;
    logic             timeout_s;
    logic [CNT_W-1:0] period_s;
    logic [2:0]       duty_s;
    logic [11:0]      timer_s;

    // Level detection and edge qualification against the previous sample.
    always_comb begin
        hi_s     = |SQ_In;
        rise_s   = hi_s & ~prev_hi_r;
        period_s = hcnt_r + lcnt_r;
        duty_s   = classify_duty(hcnt_r, period_s);
        timer_s  = classify_timer(period_s);
    end

    // Next-state and run-length counter logic.
    always_comb begin
        state_nxt_s = state_r;
        hcnt_nxt_s  = hcnt_r;
        lcnt_nxt_s  = lcnt_r;
        vol_nxt_s   = vol_r;
        var_nxt_s   = var_r;
        start_s     = 1'b0;
        complete_s  = 1'b0;
        timeout_s   = 1'b0;
        if (!EN) begin
            state_nxt_s = ST_IDLE;
            hcnt_nxt_s  = ZERO_C;
            lcnt_nxt_s  = ZERO_C;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_nxt_s = ST_HIGH;
                        hcnt_nxt_s  = ONE_C;
                        lcnt_nxt_s  = ZERO_C;
                        vol_nxt_s   = SQ_In;
                        var_nxt_s   = 1'b0;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (hcnt_r == TIMEOUT_C) begin
                        state_nxt_s = ST_IDLE;
                        hcnt_nxt_s  = ZERO_C;
                        lcnt_nxt_s  = ZERO_C;
                        timeout_s   = 1'b1;
                    end else if (hi_s) begin
                        hcnt_nxt_s = hcnt_r + ONE_C;
                        if (SQ_In != vol_r) begin
                            var_nxt_s = 1'b1;
                        end else begin
                            var_nxt_s = var_r;
                        end
                    end else begin
                        state_nxt_s = ST_LOW;
                        lcnt_nxt_s  = ONE_C;
                    end
                end
                ST_LOW: begin
                    // A high sample in LOW is always a true rise, so it closes the period.
                    if (lcnt_r == TIMEOUT_C) begin
                        state_nxt_s = ST_IDLE;
                        hcnt_nxt_s  = ZERO_C;
                        lcnt_nxt_s  = ZERO_C;
                        timeout_s   = 1'b1;
                    end else if (hi_s) begin
                        state_nxt_s = ST_HIGH;
                        hcnt_nxt_s  = ONE_C;
                        lcnt_nxt_s  = ZERO_C;
                        vol_nxt_s   = SQ_In;
                        var_nxt_s   = 1'b0;
                        complete_s  = 1'b1;
                    end else begin
                        lcnt_nxt_s = lcnt_r + ONE_C;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    hcnt_nxt_s  = ZERO_C;
                    lcnt_nxt_s  = ZERO_C;
                end
            endcase
        end
    end

    // Measurement state registers.
    always_ff @(posedge ACLK) begin
        if (RES) begin
            state_r   <= ST_IDLE;
            prev_hi_r <= 1'b0;
            hcnt_r    <= ZERO_C;
            lcnt_r    <= ZERO_C;
            vol_r     <= 4'd0;
            var_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            prev_hi_r <= hi_s;
            hcnt_r    <= hcnt_nxt_s;
            lcnt_r    <= lcnt_nxt_s;
            vol_r     <= vol_nxt_s;
            var_r     <= var_nxt_s;
        end
    end

    // One-entry result slot with sticky overrun and silence tracking.
    always_ff @(posedge ACLK) begin
        if (RES) begin
            M_VALID    <= 1'b0;
            M_PERIOD   <= ZERO_C;
            M_HIGH     <= ZERO_C;
            M_VOL      <= 4'd0;
            M_VOL_VAR  <= 1'b0;
            M_DUTY     <= 2'd0;
            M_DUTY_OK  <= 1'b0;
            M_TIMER    <= 11'd0;
            M_TIMER_OK <= 1'b0;
            SILENT     <= 1'b1;
            OVERRUN    <= 1'b0;
        end else begin
            if (complete_s && (!M_VALID || M_READY)) begin
                M_VALID    <= 1'b1;
                M_PERIOD   <= period_s;
                M_HIGH     <= hcnt_r;
                M_VOL      <= vol_r;
                M_VOL_VAR  <= var_r;
                M_DUTY     <= duty_s[1:0];
                M_DUTY_OK  <= duty_s[2];
                M_TIMER    <= timer_s[10:0];
                M_TIMER_OK <= timer_s[11];
            end else if (complete_s) begin
                OVERRUN <= 1'b1;
            end else if (M_VALID && M_READY) begin
                M_VALID <= 1'b0;
            end else begin
                M_VALID <= M_VALID;
            end
            if (start_s) begin
                SILENT <= 1'b0;
            end else if (timeout_s) begin
                SILENT <= 1'b1;
            end else begin
                SILENT <= SILENT;
            end
        end
    end

endmodule

// File: tb/tb_sq_wave_decoder.sv
// Directed bench for sq_wave_decoder: hand-computed run lengths, duty/timer codes and handshake cases.
module tb_sq_wave_decoder;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20000;

    logic             ACLK;
    logic             RES;
    logic [3:0]       SQ_In;
    logic             EN;
    logic             M_VALID;
    logic             M_READY;
    logic [CNT_W-1:0] M_PERIOD;
    logic [CNT_W-1:0] M_HIGH;
    logic [3:0]       M_VOL;
    logic             M_VOL_VAR;
    logic [1:0]       M_DUTY;
    logic             M_DUTY_OK;
    logic [10:0]      M_TIMER;
    logic             M_TIMER_OK;
    logic             SILENT;
    logic             OVERRUN;

    int vectors;
    int miscompares;

    sq_wave_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .ACLK(ACLK), .RES(RES), .SQ_In(SQ_In), .EN(EN),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_PERIOD(M_PERIOD), .M_HIGH(M_HIGH),
        .M_VOL(M_VOL), .M_VOL_VAR(M_VOL_VAR), .M_DUTY(M_DUTY), .M_DUTY_OK(M_DUTY_OK),
        .M_TIMER(M_TIMER), .M_TIMER_OK(M_TIMER_OK), .SILENT(SILENT), .OVERRUN(OVERRUN)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Drive one value for n cycles; outputs are observed 1 time unit after each edge.
    task automatic run_phase(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            SQ_In = v;
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic do_reset();
        SQ_In = 4'd0;
        RES   = 1'b1;
        @(posedge ACLK);
        #1;
        RES = 1'b0;
    endtask

    task automatic test_reset();
        int seen_valid;
        EN = 1'b1;
        M_READY = 1'b1;
        do_reset();
        vectors++; if (M_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0d expected 0", M_VALID); end
        vectors++; if (SILENT !== 1'b1) begin miscompares++; $display("FAIL reset_silent: got %0d expected 1", SILENT); end
        vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %0d expected 0", OVERRUN); end
        vectors++; if (M_PERIOD !== 16'd0) begin miscompares++; $display("FAIL reset_period: got %0d expected 0", M_PERIOD); end
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            run_phase(4'd0, 1);
            if (M_VALID === 1'b1) seen_valid++;
        end
        vectors++; if (seen_valid !== 0) begin miscompares++; $display("FAIL reset_idle_no_result: got %0d valid cycles expected 0", seen_valid); end
    endtask

    task automatic test_basic();
        M_READY = 1'b1;
        do_reset();
        run_phase(4'd9, 4);
        run_phase(4'd0, 12);
        vectors++; if (M_VALID !== 1'b0) begin miscompares++; $display("FAIL basic_first_period: got %0d expected 0", M_VALID); end
        run_phase(4'd9, 1);
        vectors++; if (M_VALID !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0d expected 1", M_VALID); end
        vectors++; if (M_PERIOD !== 16'd16) begin miscompares++; $display("FAIL basic_period: got %0d expected 16", M_PERIOD); end
        vectors++; if (M_HIGH !== 16'd4) begin miscompares++; $display("FAIL basic_high: got %0d expected 4", M_HIGH); end
        vectors++; if (M_DUTY !== 2'd1 || M_DUTY_OK !== 1'b1) begin miscompares++; $display("FAIL basic_duty: got %0d/%0d expected 1/1", M_DUTY, M_DUTY_OK); end
        vectors++; if (M_TIMER !== 11'd1 || M_TIMER_OK !== 1'b1) begin miscompares++; $display("FAIL basic_timer: got %0d/%0d expected 1/1", M_TIMER, M_TIMER_OK); end
        vectors++; if (M_VOL !== 4'd9 || M_VOL_VAR !== 1'b0) begin miscompares++; $display("FAIL basic_vol: got %0d/%0d expected 9/0", M_VOL, M_VOL_VAR); end
        vectors++; if (SILENT !== 1'b0) begin miscompares++; $display("FAIL basic_silent: got %0d expected 0", SILENT); end
        run_phase(4'd9, 1);
        vectors++; if (M_VALID !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop: got %0d expected 0", M_VALID); end
    endtask

    task automatic test_duty75();
        M_READY = 1'b1;
        do_reset();
        run_phase(4'd15, 48);
        run_phase(4'd0, 16);
        run_phase(4'd15, 1);
        vectors++; if (M_VALID !== 1'b1 || M_PERIOD !== 16'd64) begin miscompares++; $display("FAIL duty75_period: got %0d/%0d expected 1/64", M_VALID, M_PERIOD); end
        vectors++; if (M_DUTY !== 2'd3 || M_DUTY_OK !== 1'b1) begin miscompares++; $display("FAIL duty75_duty: got %0d/%0d expected 3/1", M_DUTY, M_DUTY_OK); end
        vectors++; if (M_TIMER !== 11'd7 || M_TIMER_OK !== 1'b1) begin miscompares++; $display("FAIL duty75_timer: got %0d/%0d expected 7/1", M_TIMER, M_TIMER_OK); end
    endtask

    task automatic test_silent();
        M_READY = 1'b1;
        do_reset();
        run_phase(4'd9, 4);
        run_phase(4'd0, 12);
        run_phase(4'd9, 1);
        vectors++; if (M_VALID !== 1'b1) begin miscompares++; $display("FAIL silent_lock: got %0d expected 1", M_VALID); end
        run_phase(4'd9, 3);
        run_phase(4'd0, TIMEOUT);
        vectors++; if (SILENT !== 1'b0) begin miscompares++; $display("FAIL silent_early: got %0d expected 0", SILENT); end
        run_phase(4'd0, 1);
        vectors++; if (SILENT !== 1'b1 || M_VALID !== 1'b0) begin miscompares++; $display("FAIL silent_timeout: got silent %0d valid %0d expected 1/0", SILENT, M_VALID); end
        run_phase(4'd5, 1);
        vectors++; if (SILENT !== 1'b0 || M_VALID !== 1'b0) begin miscompares++; $display("FAIL silent_restart: got silent %0d valid %0d expected 0/0", SILENT, M_VALID); end
        run_phase(4'd5, 1);
        run_phase(4'd0, 6);
        run_phase(4'd5, 1);
        vectors++; if (M_VALID !== 1'b1 || M_PERIOD !== 16'd8 || M_HIGH !== 16'd2) begin miscompares++; $display("FAIL silent_relock: got %0d/%0d/%0d expected 1/8/2", M_VALID, M_PERIOD, M_HIGH); end
        vectors++; if (M_DUTY !== 2'd1 || M_TIMER !== 11'd0 || M_TIMER_OK !== 1'b1 || M_VOL !== 4'd5) begin miscompares++; $display("FAIL silent_relock_class: got duty %0d timer %0d ok %0d vol %0d expected 1/0/1/5", M_DUTY, M_TIMER, M_TIMER_OK, M_VOL); end
    endtask

    task automatic test_backpressure();
        M_READY = 1'b0;
        do_reset();
        run_phase(4'd7, 16);
        run_phase(4'd0, 16);
        run_phase(4'd7, 1);
        vectors++; if (M_VALID !== 1'b1 || M_PERIOD !== 16'd32 || OVERRUN !== 1'b0) begin miscompares++; $display("FAIL bp_first: got %0d/%0d/%0d expected 1/32/0", M_VALID, M_PERIOD, OVERRUN); end
        run_phase(4'd7, 7);
        run_phase(4'd0, 8);
        run_phase(4'd7, 1);
        vectors++; if (M_VALID !== 1'b1 || M_PERIOD !== 16'd32 || M_HIGH !== 16'd16) begin miscompares++; $display("FAIL bp_hold: got %0d/%0d/%0d expected 1/32/16", M_VALID, M_PERIOD, M_HIGH); end
        vectors++; if (M_DUTY !== 2'd2 || OVERRUN !== 1'b1) begin miscompares++; $display("FAIL bp_overrun: got duty %0d overrun %0d expected 2/1", M_DUTY, OVERRUN); end
        M_READY = 1'b1;
        run_phase(4'd7, 1);
        vectors++; if (M_VALID !== 1'b0 || OVERRUN !== 1'b1) begin miscompares++; $display("FAIL bp_release: got valid %0d overrun %0d expected 0/1", M_VALID, OVERRUN); end
    endtask

    task automatic test_vol_var();
        M_READY = 1'b1;
        do_reset();
        run_phase(4'd9, 2);
        run_phase(4'd5, 2);
        run_phase(4'd0, 12);
        run_phase(4'd9, 1);
        vectors++; if (M_VALID !== 1'b1 || M_VOL !== 4'd9 || M_VOL_VAR !== 1'b1) begin miscompares++; $display("FAIL volvar_vol: got %0d/%0d/%0d expected 1/9/1", M_VALID, M_VOL, M_VOL_VAR); end
        vectors++; if (M_DUTY !== 2'd1 || M_DUTY_OK !== 1'b1) begin miscompares++; $display("FAIL volvar_duty: got %0d/%0d expected 1/1", M_DUTY, M_DUTY_OK); end
        run_phase(4'd9, 2);
        run_phase(4'd0, 13);
        run_phase(4'd9, 1);
        vectors++; if (M_PERIOD !== 16'd16 || M_HIGH !== 16'd3 || M_VOL_VAR !== 1'b0) begin miscompares++; $display("FAIL odd_duty_len: got %0d/%0d/%0d expected 16/3/0", M_PERIOD, M_HIGH, M_VOL_VAR); end
        vectors++; if (M_DUTY !== 2'd0 || M_DUTY_OK !== 1'b0) begin miscompares++; $display("FAIL odd_duty_class: got %0d/%0d expected 0/0", M_DUTY, M_DUTY_OK); end
        vectors++; if (M_TIMER !== 11'd1 || M_TIMER_OK !== 1'b1) begin miscompares++; $display("FAIL odd_duty_timer: got %0d/%0d expected 1/1", M_TIMER, M_TIMER_OK); end
    endtask

    task automatic test_enable();
        M_READY = 1'b1;
        do_reset();
        run_phase(4'd9, 4);
        run_phase(4'd0, 4);
        EN = 1'b0;
        run_phase(4'd0, 2);
        EN = 1'b1;
        vectors++; if (SILENT !== 1'b0) begin miscompares++; $display("FAIL enable_silent_held: got %0d expected 0", SILENT); end
        run_phase(4'd0, 4);
        run_phase(4'd9, 1);
        vectors++; if (M_VALID !== 1'b0) begin miscompares++; $display("FAIL enable_restart: got %0d expected 0", M_VALID); end
        run_phase(4'd9, 3);
        run_phase(4'd0, 4);
        run_phase(4'd9, 1);
        vectors++; if (M_VALID !== 1'b1 || M_PERIOD !== 16'd8 || M_DUTY !== 2'd2 || M_TIMER !== 11'd0) begin miscompares++; $display("FAIL enable_result: got %0d/%0d/%0d/%0d expected 1/8/2/0", M_VALID, M_PERIOD, M_DUTY, M_TIMER); end
    endtask

    task automatic test_timer_max();
        M_READY = 1'b1;
        do_reset();
        run_phase(4'd3, 8192);
        run_phase(4'd0, 8192);
        run_phase(4'd3, 1);
        vectors++; if (M_VALID !== 1'b1 || M_PERIOD !== 16'd16384) begin miscompares++; $display("FAIL timer_max_period: got %0d/%0d expected 1/16384", M_VALID, M_PERIOD); end
        vectors++; if (M_TIMER !== 11'd2047 || M_TIMER_OK !== 1'b1 || M_DUTY !== 2'd2) begin miscompares++; $display("FAIL timer_max_class: got %0d/%0d/%0d expected 2047/1/2", M_TIMER, M_TIMER_OK, M_DUTY); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RES = 1'b1;
        EN = 1'b1;
        M_READY = 1'b1;
        SQ_In = 4'd0;
        test_reset();
        test_basic();
        test_duty75();
        test_silent();
        test_backpressure();
        test_vol_var();
        test_enable();
        test_timer_max();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
